// File: rtl/tile_blitter.sv
// Tile blitter: copies one TILE_W x TILE_H RGB tile from byte-wide ROM to a pixel-write port,
// with X/Y flip, colour-key transparency and valid/ready backpressure on the pixel output.
module tile_blitter #(
  parameter int TILE_W  = 8,
  parameter int TILE_H  = 8,
  parameter int COORD_W = 8,
  parameter int IDX_W   = 6,
  parameter int ADDR_W  = 12,
  parameter int CH_W    = 8,
  parameter int ROM_LAT = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [IDX_W-1:0]     tile_idx_i,
  input  logic [COORD_W-1:0]   x_pos_i,
  input  logic [COORD_W-1:0]   y_pos_i,
  input  logic                 flip_x_i,
  input  logic                 flip_y_i,
  input  logic                 key_en_i,
  input  logic [3*CH_W-1:0]    key_rgb_i,
  output logic [ADDR_W-1:0]    rom_addr_o,
  input  logic [CH_W-1:0]      rom_data_i,
  output logic                 pix_valid_o,
  input  logic                 pix_ready_i,
  output logic [COORD_W-1:0]   pix_x_o,
  output logic [COORD_W-1:0]   pix_y_o,
  output logic [3*CH_W-1:0]    pix_rgb_o,
  output logic                 busy_o,
  output logic                 done_o
);

  // state | meaning
  // IDLE  | waiting for start
  // FETCH | issue R,G,B addresses and capture the returning bytes
  // EMIT  | present pixel until accepted (skipped at once if it matches the key)
  // NEXT  | advance col/row, load next pixel's R address
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EMIT, S_NEXT, S_DONE} state_t;

  localparam int CW         = $clog2(TILE_W);
  localparam int RW         = $clog2(TILE_H);
  localparam int FC_W       = 3;
  localparam int TILE_BYTES = TILE_W * TILE_H * 3;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     tile_q, tile_d;
  logic [COORD_W-1:0]   xpos_q, xpos_d, ypos_q, ypos_d;
  logic                 fx_q, fx_d, fy_q, fy_d, ken_q, ken_d;
  logic [3*CH_W-1:0]    key_q, key_d;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [FC_W-1:0]      fcnt_q, fcnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [CH_W-1:0]      r_q, r_d, g_q, g_d;
  logic [COORD_W-1:0]   px_q, px_d, py_q, py_d;
  logic [3*CH_W-1:0]    rgb_q, rgb_d;

  logic                 key_hit;
  logic                 last_pix;
  logic [CW-1:0]        ncol;
  logic [RW-1:0]        nrow;

  // With power-of-2 dimensions, N-1-i equals the bitwise inverse of i.
  function automatic logic [ADDR_W-1:0] red_addr(input logic [IDX_W-1:0] t,
                                                 input logic fx, input logic fy,
                                                 input logic [CW-1:0] c, input logic [RW-1:0] r);
    logic [CW-1:0] sc;
    logic [RW-1:0] sr;
    logic [31:0]   a;
    sc = fx ? ~c : c;
    sr = fy ? ~r : r;
    a  = 32'(t) * 32'(TILE_BYTES) + (32'(sr) * 32'(TILE_W) + 32'(sc)) * 32'd3;
    return a[ADDR_W-1:0];
  endfunction

  assign key_hit  = ken_q && (rgb_q == key_q);
  assign last_pix = (&col_q) && (&row_q);
  assign ncol     = col_q + CW'(1);
  assign nrow     = (&col_q) ? row_q + RW'(1) : row_q;

  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    ken_d   = ken_q;
    key_d   = key_q;
    col_d   = col_q;
    row_d   = row_q;
    fcnt_d  = fcnt_q;
    addr_d  = addr_q;
    r_d     = r_q;
    g_d     = g_q;
    px_d    = px_q;
    py_d    = py_q;
    rgb_d   = rgb_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          tile_d  = tile_idx_i;
          xpos_d  = x_pos_i;
          ypos_d  = y_pos_i;
          fx_d    = flip_x_i;
          fy_d    = flip_y_i;
          ken_d   = key_en_i;
          key_d   = key_rgb_i;
          col_d   = '0;
          row_d   = '0;
          fcnt_d  = '0;
          addr_d  = red_addr(tile_idx_i, flip_x_i, flip_y_i, '0, '0);
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        fcnt_d = fcnt_q + FC_W'(1);
        if (fcnt_q < FC_W'(2)) addr_d = addr_q + ADDR_W'(1);
        if (fcnt_q == FC_W'(ROM_LAT)) r_d = rom_data_i;
        if (fcnt_q == FC_W'(ROM_LAT + 1)) g_d = rom_data_i;
        if (fcnt_q == FC_W'(ROM_LAT + 2)) begin
          rgb_d   = {r_q, g_q, rom_data_i};
          px_d    = xpos_q + COORD_W'(col_q);
          py_d    = ypos_q + COORD_W'(row_q);
          fcnt_d  = '0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (key_hit || pix_ready_i) state_d = S_NEXT;
      end
      S_NEXT: begin
        col_d = ncol;
        row_d = nrow;
        if (last_pix) begin
          state_d = S_DONE;
        end else begin
          addr_d  = red_addr(tile_q, fx_q, fy_q, ncol, nrow);
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      tile_q  <= '0;
      xpos_q  <= '0;
      ypos_q  <= '0;
      fx_q    <= 1'b0;
      fy_q    <= 1'b0;
      ken_q   <= 1'b0;
      key_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      fcnt_q  <= '0;
      addr_q  <= '0;
      r_q     <= '0;
      g_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      ken_q   <= ken_d;
      key_q   <= key_d;
      col_q   <= col_d;
      row_q   <= row_d;
      fcnt_q  <= fcnt_d;
      addr_q  <= addr_d;
      r_q     <= r_d;
      g_q     <= g_d;
      px_q    <= px_d;
      py_q    <= py_d;
      rgb_q   <= rgb_d;
    end
  end

  assign rom_addr_o  = addr_q;
  assign pix_valid_o = (state_q == S_EMIT) && !key_hit;
  assign pix_x_o     = px_q;
  assign pix_y_o     = py_q;
  assign pix_rgb_o   = rgb_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_tile_blitter.sv
// Bench for tile_blitter: two instances (ROM latency 1 and 3) fed from a shared random ROM,
// each draw compared against a per-pixel reference list built from the drawing rules.
module tb_tile_blitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_s[2], fx_s[2], fy_s[2], ken_s[2], rdy_s[2];
  logic [5:0]  idx_s[2];
  logic [7:0]  x_s[2], y_s[2];
  logic [23:0] key_s[2];
  logic [11:0] addr_s[2];
  logic [7:0]  data_s[2];
  logic        pv_s[2], busy_s[2], done_s[2];
  logic [7:0]  px_s[2], py_s[2];
  logic [23:0] prgb_s[2];

  logic [7:0]  rom [4096];
  logic [11:0] ap0;
  logic [11:0] ap1 [3];

  logic [39:0] act_q[2][$];
  logic [11:0] alog[2][$];
  int          stall_err[2], done_cnt[2], pv_cnt[2];
  logic        held[2];
  logic [39:0] hold_v[2];

  logic [39:0] exp_q[$];
  logic [11:0] exp_a[$];
  int          total = 0;
  int          bad = 0;

  tile_blitter #(.ROM_LAT(1)) u0 (
    .clk_i(clk), .reset_i(rst), .start_i(start_s[0]), .tile_idx_i(idx_s[0]),
    .x_pos_i(x_s[0]), .y_pos_i(y_s[0]), .flip_x_i(fx_s[0]), .flip_y_i(fy_s[0]),
    .key_en_i(ken_s[0]), .key_rgb_i(key_s[0]), .rom_addr_o(addr_s[0]), .rom_data_i(data_s[0]),
    .pix_valid_o(pv_s[0]), .pix_ready_i(rdy_s[0]), .pix_x_o(px_s[0]), .pix_y_o(py_s[0]),
    .pix_rgb_o(prgb_s[0]), .busy_o(busy_s[0]), .done_o(done_s[0]));

  tile_blitter #(.ROM_LAT(3)) u1 (
    .clk_i(clk), .reset_i(rst), .start_i(start_s[1]), .tile_idx_i(idx_s[1]),
    .x_pos_i(x_s[1]), .y_pos_i(y_s[1]), .flip_x_i(fx_s[1]), .flip_y_i(fy_s[1]),
    .key_en_i(ken_s[1]), .key_rgb_i(key_s[1]), .rom_addr_o(addr_s[1]), .rom_data_i(data_s[1]),
    .pix_valid_o(pv_s[1]), .pix_ready_i(rdy_s[1]), .pix_x_o(px_s[1]), .pix_y_o(py_s[1]),
    .pix_rgb_o(prgb_s[1]), .busy_o(busy_s[1]), .done_o(done_s[1]));

  // ROM with fixed read latency per instance
  always @(posedge clk) begin
    ap0    <= addr_s[0];
    ap1[0] <= addr_s[1];
    ap1[1] <= ap1[0];
    ap1[2] <= ap1[1];
  end
  assign data_s[0] = rom[ap0];
  assign data_s[1] = rom[ap1[2]];

  always @(negedge clk) begin : mon
    logic [39:0] cur;
    for (int d = 0; d < 2; d++) begin
      cur = {px_s[d], py_s[d], prgb_s[d]};
      if (held[d] && (!pv_s[d] || cur !== hold_v[d])) stall_err[d]++;
      held[d]   = pv_s[d] && !rdy_s[d];
      hold_v[d] = cur;
      if (pv_s[d] && rdy_s[d]) act_q[d].push_back(cur);
      if (pv_s[d]) pv_cnt[d]++;
      if (done_s[d]) done_cnt[d]++;
      if (busy_s[d] && (alog[d].size() == 0 || alog[d][alog[d].size()-1] != addr_s[d]))
        alog[d].push_back(addr_s[d]);
    end
  end

  task automatic build_exp(input logic [5:0] idx, input logic [7:0] x, input logic [7:0] y,
                           input logic fx, input logic fy, input logic ken, input logic [23:0] key);
    int sc, sr, b, px, py;
    logic [23:0] rgb;
    exp_q.delete();
    exp_a.delete();
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        sc = fx ? 7 - c : c;
        sr = fy ? 7 - r : r;
        b  = (int'(idx) * 192 + (sr * 8 + sc) * 3) % 4096;
        exp_a.push_back(12'(b));
        exp_a.push_back(12'((b + 1) % 4096));
        exp_a.push_back(12'((b + 2) % 4096));
        rgb = {rom[b], rom[(b + 1) % 4096], rom[(b + 2) % 4096]};
        px  = (int'(x) + c) % 256;
        py  = (int'(y) + r) % 256;
        if (!(ken && rgb == key)) exp_q.push_back({px[7:0], py[7:0], rgb});
      end
    end
  endtask

  task automatic clear_mon(input int d);
    act_q[d].delete();
    alog[d].delete();
    stall_err[d] = 0;
    done_cnt[d]  = 0;
    pv_cnt[d]    = 0;
  endtask

  // Starts one draw, scrambles the inputs after accept, waits for done (bounded).
  task automatic run_tile(input int d, input logic [5:0] idx, input logic [7:0] x, input logic [7:0] y,
                          input logic fx, input logic fy, input logic ken, input logic [23:0] key,
                          input bit rnd_rdy, input bit poke, output int cyc);
    clear_mon(d);
    idx_s[d] = idx; x_s[d] = x; y_s[d] = y;
    fx_s[d] = fx; fy_s[d] = fy; ken_s[d] = ken; key_s[d] = key;
    start_s[d] = 1'b1;
    rdy_s[d] = 1'b1;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
    idx_s[d] = 6'($urandom); x_s[d] = 8'($urandom); y_s[d] = 8'($urandom);
    fx_s[d] = ~fx; fy_s[d] = ~fy; ken_s[d] = ~ken; key_s[d] = 24'($urandom);
    cyc = 1;
    while (!done_s[d] && cyc < 6000) begin
      rdy_s[d] = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) start_s[d] = (cyc == 50);
      @(posedge clk); #1;
      cyc++;
    end
    start_s[d] = 1'b0;
    rdy_s[d] = 1'b1;
    total++;
    if (!done_s[d]) begin
      bad++;
      $display("FAIL done_timeout dut=%0d cycles=%0d required done within 6000", d, cyc);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 0; fx_s[d] = 0; fy_s[d] = 0; ken_s[d] = 0; rdy_s[d] = 1;
      idx_s[d] = 0; x_s[d] = 0; y_s[d] = 0; key_s[d] = 0;
      held[d] = 0; hold_v[d] = 0;
      clear_mon(d);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({addr_s[d], pv_s[d], px_s[d], py_s[d], prgb_s[d], busy_s[d], done_s[d]} !== 55'd0) begin
        bad++;
        $display("FAIL reset_state dut=%0d got addr=%h pv=%b x=%h y=%h rgb=%h busy=%b done=%b required all 0",
                 d, addr_s[d], pv_s[d], px_s[d], py_s[d], prgb_s[d], busy_s[d], done_s[d]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int cyc, nm;
    logic [39:0] first_e, last_e;
    build_exp(6'd0, 8'd10, 8'd20, 0, 0, 0, 24'd0);
    run_tile(0, 6'd0, 8'd10, 8'd20, 0, 0, 0, 24'd0, 0, 0, cyc);
    nm = 0;
    if (act_q[0].size() != exp_q.size()) nm = 1000;
    else foreach (exp_q[i]) if (act_q[0][i] !== exp_q[i]) nm++;
    total++;
    if (nm != 0) begin
      bad++;
      $display("FAIL basic_pixels mismatches=%0d got_n=%0d required_n=%0d", nm, act_q[0].size(), exp_q.size());
    end
    first_e = {8'd10, 8'd20, rom[0], rom[1], rom[2]};
    last_e  = {8'd17, 8'd27, rom[189], rom[190], rom[191]};
    total++;
    if (act_q[0].size() != 64 || act_q[0][0] !== first_e || act_q[0][63] !== last_e) begin
      bad++;
      $display("FAIL basic_first_last n=%0d first=%h last=%h required %h %h", act_q[0].size(),
               act_q[0][0], act_q[0][63], first_e, last_e);
    end
    total++;
    if (done_cnt[0] != 1) begin
      bad++;
      $display("FAIL basic_done_count got=%0d required=1", done_cnt[0]);
    end
    total++;
    if (cyc != 1 + 64 * 6) begin
      bad++;
      $display("FAIL basic_latency got=%0d required=%0d", cyc, 1 + 64 * 6);
    end
  endtask

  task automatic test_flip();
    int cyc, nm;
    logic [7:0] x, y;
    x = 8'($urandom); y = 8'($urandom);
    build_exp(6'd2, x, y, 1, 0, 0, 24'd0);
    run_tile(0, 6'd2, x, y, 1, 0, 0, 24'd0, 0, 0, cyc);
    total++;
    if (act_q[0].size() == 0 || act_q[0][0] !== {x, y, rom[405], rom[406], rom[407]}) begin
      bad++;
      $display("FAIL flipx_first got=%h required=%h", act_q[0][0], {x, y, rom[405], rom[406], rom[407]});
    end
    nm = 0;
    if (alog[0].size() != exp_a.size()) nm = 1000;
    else foreach (exp_a[i]) if (alog[0][i] !== exp_a[i]) nm++;
    total++;
    if (nm != 0) begin
      bad++;
      $display("FAIL flipx_rom_addr mismatches=%0d got_n=%0d required_n=%0d", nm, alog[0].size(), exp_a.size());
    end
    for (int k = 0; k < 3; k++) begin
      logic [5:0] idx;
      logic fx, fy;
      idx = 6'($urandom); fx = 1'($urandom); fy = 1'($urandom);
      x = 8'($urandom); y = 8'($urandom);
      build_exp(idx, x, y, fx, fy, 0, 24'd0);
      run_tile(0, idx, x, y, fx, fy, 0, 24'd0, 0, 0, cyc);
      nm = 0;
      if (act_q[0].size() != exp_q.size()) nm = 1000;
      else foreach (exp_q[i]) if (act_q[0][i] !== exp_q[i]) nm++;
      foreach (exp_a[i]) if (alog[0].size() != exp_a.size() || alog[0][i] !== exp_a[i]) nm++;
      total++;
      if (nm != 0) begin
        bad++;
        $display("FAIL flip_random idx=%0d fx=%b fy=%b mismatches=%0d required 0", idx, fx, fy, nm);
      end
    end
  endtask

  task automatic test_wrap();
    int cyc, nm;
    build_exp(6'd1, 8'd252, 8'd250, 0, 0, 0, 24'd0);
    run_tile(0, 6'd1, 8'd252, 8'd250, 0, 0, 0, 24'd0, 0, 0, cyc);
    nm = 0;
    if (act_q[0].size() != exp_q.size()) nm = 1000;
    else foreach (exp_q[i]) if (act_q[0][i] !== exp_q[i]) nm++;
    total++;
    if (nm != 0) begin
      bad++;
      $display("FAIL wrap_pixels mismatches=%0d required 0", nm);
    end
    total++;
    if (act_q[0].size() != 64 || act_q[0][4][39:32] !== 8'd0 || act_q[0][63][31:24] !== 8'd1) begin
      bad++;
      $display("FAIL wrap_coords x4=%0d y63=%0d required 0 and 1", act_q[0][4][39:32], act_q[0][63][31:24]);
    end
  endtask

  task automatic test_backpressure(input int d);
    int cyc, nm;
    logic [5:0] idx;
    logic [7:0] x, y;
    logic fx, fy;
    for (int k = 0; k < 2; k++) begin
      idx = 6'($urandom); x = 8'($urandom); y = 8'($urandom);
      fx = 1'($urandom); fy = 1'($urandom);
      build_exp(idx, x, y, fx, fy, 0, 24'd0);
      run_tile(d, idx, x, y, fx, fy, 0, 24'd0, 1, 0, cyc);
      nm = 0;
      if (act_q[d].size() != 64) nm = 1000;
      else foreach (exp_q[i]) if (act_q[d][i] !== exp_q[i]) nm++;
      total++;
      if (nm != 0) begin
        bad++;
        $display("FAIL stall_pixels dut=%0d got_n=%0d mismatches=%0d required 64 and 0", d, act_q[d].size(), nm);
      end
      total++;
      if (stall_err[d] != 0) begin
        bad++;
        $display("FAIL stall_stable dut=%0d changes_while_stalled=%0d required 0", d, stall_err[d]);
      end
    end
  endtask

  task automatic test_key();
    int cyc, nm, b;
    int kp[5] = '{3, 17, 30, 44, 63};
    logic [23:0] key;
    logic fx, fy;
    bit hit;
    key = 24'($urandom);
    for (int p = 0; p < 64; p++) begin
      b = 960 + 3 * p;
      hit = 0;
      foreach (kp[j]) if (kp[j] == p) hit = 1;
      if (hit) {rom[b], rom[b+1], rom[b+2]} = key;
      else if ({rom[b], rom[b+1], rom[b+2]} == key) rom[b] = rom[b] ^ 8'h01;
    end
    fx = 1'($urandom); fy = 1'($urandom);
    build_exp(6'd5, 8'd40, 8'd60, fx, fy, 1, key);
    run_tile(0, 6'd5, 8'd40, 8'd60, fx, fy, 1, key, 1, 0, cyc);
    nm = 0;
    if (act_q[0].size() != exp_q.size()) nm = 1000;
    else foreach (exp_q[i]) if (act_q[0][i] !== exp_q[i]) nm++;
    total++;
    if (act_q[0].size() != 59 || nm != 0) begin
      bad++;
      $display("FAIL key_writes got_n=%0d mismatches=%0d required 59 and 0", act_q[0].size(), nm);
    end
    for (int i = 0; i < 192; i += 3) {rom[1152+i], rom[1153+i], rom[1154+i]} = key;
    run_tile(0, 6'd6, 8'd0, 8'd0, 0, 0, 1, key, 0, 0, cyc);
    total++;
    if (pv_cnt[0] != 0 || act_q[0].size() != 0 || done_cnt[0] != 1) begin
      bad++;
      $display("FAIL key_all pv_cycles=%0d writes=%0d done=%0d required 0 0 1", pv_cnt[0], act_q[0].size(), done_cnt[0]);
    end
  endtask

  task automatic test_reset_mid();
    int n, cyc, nm, pv0;
    clear_mon(0);
    idx_s[0] = 6'd3; x_s[0] = 8'd5; y_s[0] = 8'd7;
    fx_s[0] = 0; fy_s[0] = 0; ken_s[0] = 0; rdy_s[0] = 1;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    n = 0;
    while (act_q[0].size() < 30 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (act_q[0].size() < 30) begin
      bad++;
      $display("FAIL midreset_reach writes=%0d required 30", act_q[0].size());
    end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({addr_s[0], pv_s[0], px_s[0], py_s[0], prgb_s[0], busy_s[0], done_s[0]} !== 55'd0) begin
      bad++;
      $display("FAIL midreset_outputs addr=%h pv=%b x=%h y=%h rgb=%h busy=%b done=%b required all 0",
               addr_s[0], pv_s[0], px_s[0], py_s[0], prgb_s[0], busy_s[0], done_s[0]);
    end
    rst = 1'b0;
    pv0 = pv_cnt[0];
    repeat (60) @(posedge clk);
    #1;
    total++;
    if (pv_cnt[0] != pv0 || done_cnt[0] != 0 || busy_s[0] !== 1'b0) begin
      bad++;
      $display("FAIL midreset_quiet pv_cycles=%0d done=%0d busy=%b required %0d 0 0", pv_cnt[0], done_cnt[0], busy_s[0], pv0);
    end
    build_exp(6'd3, 8'd5, 8'd7, 0, 0, 0, 24'd0);
    run_tile(0, 6'd3, 8'd5, 8'd7, 0, 0, 0, 24'd0, 0, 0, cyc);
    nm = 0;
    if (act_q[0].size() != exp_q.size()) nm = 1000;
    else foreach (exp_q[i]) if (act_q[0][i] !== exp_q[i]) nm++;
    total++;
    if (nm != 0 || done_cnt[0] != 1) begin
      bad++;
      $display("FAIL midreset_fresh mismatches=%0d done=%0d required 0 1", nm, done_cnt[0]);
    end
  endtask

  task automatic test_start_ignored();
    int cyc, nm;
    build_exp(6'd9, 8'd100, 8'd30, 1, 1, 0, 24'd0);
    run_tile(0, 6'd9, 8'd100, 8'd30, 1, 1, 0, 24'd0, 0, 1, cyc);
    nm = 0;
    if (act_q[0].size() != exp_q.size()) nm = 1000;
    else foreach (exp_q[i]) if (act_q[0][i] !== exp_q[i]) nm++;
    total++;
    if (nm != 0 || cyc != 1 + 64 * 6 || done_cnt[0] != 1) begin
      bad++;
      $display("FAIL start_busy mismatches=%0d cycles=%0d done=%0d required 0 %0d 1", nm, cyc, done_cnt[0], 1 + 64 * 6);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_mon(0);
    idx_s[0] = 6'd4; x_s[0] = 8'd0; y_s[0] = 8'd0;
    fx_s[0] = 0; fy_s[0] = 0; ken_s[0] = 0; rdy_s[0] = 1;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    n = 1;
    while (!done_s[0] && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    total++;
    if (busy_s[0] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done_start busy=%b required 0 after done cycle", busy_s[0]);
    end
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    total++;
    if (busy_s[0] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_idle_accept busy=%b required 1", busy_s[0]);
    end
    n = 0;
    while (!done_s[0] && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (done_cnt[0] != 2) begin
      bad++;
      $display("FAIL b2b_done_count got=%0d required=2", done_cnt[0]);
    end
  endtask

  task automatic test_lat3();
    int cyc, nm;
    build_exp(6'd0, 8'd10, 8'd20, 0, 0, 0, 24'd0);
    run_tile(1, 6'd0, 8'd10, 8'd20, 0, 0, 0, 24'd0, 0, 0, cyc);
    nm = 0;
    if (act_q[1].size() != exp_q.size()) nm = 1000;
    else foreach (exp_q[i]) if (act_q[1][i] !== exp_q[i]) nm++;
    total++;
    if (nm != 0 || done_cnt[1] != 1) begin
      bad++;
      $display("FAIL lat3_pixels mismatches=%0d done=%0d required 0 1", nm, done_cnt[1]);
    end
    total++;
    if (cyc != 1 + 64 * 8) begin
      bad++;
      $display("FAIL lat3_latency got=%0d required=%0d", cyc, 1 + 64 * 8);
    end
    test_backpressure(1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_flip();
    test_wrap();
    test_backpressure(0);
    test_key();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_lat3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
